// File: rtl/vgachargen_pkg.sv
// Shared types, default timing and palette for the VGA character generator.
package vgachargen_pkg;

  typedef logic [11:0] rgb12_t;

  // 640x480@60 defaults, pixels / lines
  localparam int H_DISP_DEF  = 640;
  localparam int H_FP_DEF    = 16;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BP_DEF    = 48;
  localparam int V_DISP_DEF  = 480;
  localparam int V_FP_DEF    = 10;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BP_DEF    = 33;

  localparam rgb12_t DEFAULT_PALETTE [16] = '{
    12'h000, 12'h000, 12'h00D, 12'h00F, 12'hD00, 12'hF00, 12'hD0D, 12'hF0F,
    12'h0D0, 12'h0F0, 12'h0DD, 12'h0FF, 12'hDD0, 12'hFF0, 12'hDDD, 12'hFFF
  };

  function automatic logic sync_window(input int cnt, input int disp, input int fp, input int sw);
    return (cnt >= disp + fp) && (cnt < disp + fp + sw);
  endfunction

  function automatic logic hsync_window(input int hcnt, input int hd, input int hf, input int hr);
    return sync_window(hcnt, hd, hf, hr);
  endfunction

  function automatic logic vsync_window(input int vcnt, input int vd, input int vf, input int vr);
    return sync_window(vcnt, vd, vf, vr);
  endfunction

  function automatic rgb12_t color_decode(input logic [3:0] idx);
    return DEFAULT_PALETTE[idx];
  endfunction

endpackage

// File: rtl/vgachargen_palette.sv
// 16-entry palette with registered read into the output stage.
// VGACHARGEN_PALETTE_WR_EN: writable register file; otherwise constant default table.
module vgachargen_palette
  import vgachargen_pkg::*;
(
  input  logic       clk_i,
  input  logic       arstn_i,
  input  logic       clr_i,
  input  logic       adv_i,
  input  logic       de_i,
  input  logic [3:0] idx_i,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  rgb12_t     wdata_i,
  output rgb12_t     rgb_o
);

  rgb12_t rd;

`ifdef VGACHARGEN_PALETTE_WR_EN
  rgb12_t pal_q [16];

  // Writes ignore the raster enable; a same-edge read sees the old entry.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= DEFAULT_PALETTE[i];
    end else if (we_i) begin
      pal_q[waddr_i] <= wdata_i;
    end
  end

  assign rd = pal_q[idx_i];
`else
  logic unused_wr;
  assign unused_wr = ^{we_i, waddr_i, wdata_i};
  assign rd = color_decode(idx_i);
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i)   rgb_o <= '0;
    else if (clr_i) rgb_o <= '0;
    else if (adv_i) rgb_o <= de_i ? rd : '0;
  end

endmodule

// File: rtl/vgachargen_timing_gen.sv
// VGA raster engine: pixel strobe, counters, sync/blank and 2-stage palette pipeline.
// Optional writable palette via VGACHARGEN_PALETTE_WR_EN.
module vgachargen_timing_gen
  import vgachargen_pkg::*;
#(
  parameter int HD        = H_DISP_DEF,
  parameter int HF        = H_FP_DEF,
  parameter int HR        = H_SYNC_DEF,
  parameter int HB        = H_BP_DEF,
  parameter int VD        = V_DISP_DEF,
  parameter int VF        = V_FP_DEF,
  parameter int VR        = V_SYNC_DEF,
  parameter int VB        = V_BP_DEF,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 4
) (
  input  logic                                 clk_i,
  input  logic                                 arstn_i,
  input  logic                                 en_i,
  output logic                                 pix_stb_o,
  output logic [$clog2(HD+HF+HR+HB)-1:0]       hcount_o,
  output logic [$clog2(VD+VF+VR+VB)-1:0]       vcount_o,
  output logic                                 req_de_o,
  output logic                                 frame_start_o,
  input  logic [3:0]                           color_idx_i,
  input  logic                                 pal_we_i,
  input  logic [3:0]                           pal_waddr_i,
  input  logic [11:0]                          pal_wdata_i,
  output logic                                 hsync_o,
  output logic                                 vsync_o,
  output logic [11:0]                          rgb_o
);

  localparam int HTOTAL = HD + HF + HR + HB;
  localparam int VTOTAL = VD + VF + VR + VB;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic          div_last, h_last, v_last;
  logic [3:0]    idx1_q;
  logic          de1_q, hs1_q, vs1_q;

  assign div_last = (div_q == DW'(CLK_DIV - 1));
  assign h_last   = (hcount_o == HW'(HTOTAL - 1));
  assign v_last   = (vcount_o == VW'(VTOTAL - 1));

  // Strobe is registered off the divider wrap, so the first one lands CLK_DIV edges after enable.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      div_q     <= '0;
      pix_stb_o <= 1'b0;
    end else if (!en_i) begin
      div_q     <= '0;
      pix_stb_o <= 1'b0;
    end else begin
      div_q     <= div_last ? '0 : div_q + DW'(1);
      pix_stb_o <= div_last;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hcount_o <= '0;
      vcount_o <= '0;
    end else if (!en_i) begin
      hcount_o <= '0;
      vcount_o <= '0;
    end else if (pix_stb_o) begin
      hcount_o <= h_last ? '0 : hcount_o + HW'(1);
      if (h_last) vcount_o <= v_last ? '0 : vcount_o + VW'(1);
    end
  end

  assign req_de_o      = (hcount_o < HW'(HD)) && (vcount_o < VW'(VD));
  assign frame_start_o = pix_stb_o && (hcount_o == '0) && (vcount_o == '0);

  // S1 keeps sync as active-high flags; polarity is applied entering S2.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      idx1_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else if (!en_i) begin
      idx1_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else if (pix_stb_o) begin
      idx1_q <= color_idx_i;
      de1_q  <= req_de_o;
      hs1_q  <= hsync_window(int'(hcount_o), HD, HF, HR);
      vs1_q  <= vsync_window(int'(vcount_o), VD, VF, VR);
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      hsync_o <= ~HSYNC_POL;
      vsync_o <= ~VSYNC_POL;
    end else if (!en_i) begin
      hsync_o <= ~HSYNC_POL;
      vsync_o <= ~VSYNC_POL;
    end else if (pix_stb_o) begin
      hsync_o <= hs1_q ? HSYNC_POL : ~HSYNC_POL;
      vsync_o <= vs1_q ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  vgachargen_palette u_palette (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .clr_i   (~en_i),
    .adv_i   (pix_stb_o),
    .de_i    (de1_q),
    .idx_i   (idx1_q),
    .we_i    (pal_we_i),
    .waddr_i (pal_waddr_i),
    .wdata_i (pal_wdata_i),
    .rgb_o   (rgb_o)
  );

endmodule
